// File: rtl/rx_fifo_stage.sv
// rx_fifo_stage: first-word fall-through byte FIFO between the 8N1 Rx unit and the host.
// Build option RX_FIFO_THRESH_EN: irq_o fires on a programmable fill level instead of non-empty.
module rx_fifo_stage #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  rxav_i,
    input  logic [7:0]            rxdata_i,
    output logic                  rxread_o,
    input  logic                  rd_i,
    output logic [7:0]            data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overrun_o,
    input  logic                  clr_ovr_i,
    input  logic [DEPTH_LOG2:0]   thresh_i,
    output logic                  irq_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovr_q, ovr_d;
    logic                  irq_q, irq_d;
    logic                  push, pop, drop;

    // Every presented byte is acknowledged at once, whether it is stored or dropped.
    assign rxread_o = rxav_i;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte.
    assign pop  = rd_i & ~empty_o;
    assign push = rxav_i & (~full_o | pop);
    assign drop = rxav_i & ~push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        ovr_d = drop | (ovr_q & ~clr_ovr_i);
    end

`ifdef RX_FIFO_THRESH_EN
    logic [DEPTH_LOG2:0] thresh_eff;
    assign thresh_eff = (thresh_i == '0) ? (DEPTH_LOG2 + 1)'(1) : thresh_i;
    assign irq_d      = (count_d >= thresh_eff) | ovr_d;
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh_i;
    assign irq_d         = (count_d != '0) | ovr_d;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_d;
        end
    end

    // Storage is deliberately not reset; count gating keeps stale entries invisible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rxdata_i;
        end
    end

    assign data_o    = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign overrun_o = ovr_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_rx_fifo_stage.sv
// Self-checking bench for rx_fifo_stage: directed scenarios plus randomized traffic vs a queue model.
module tb_rx_fifo_stage;
    localparam int DL    = 4;
    localparam int DEPTH = 2 ** DL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rxav, rd, clr;
    logic [7:0]    rxd;
    logic [DL:0]   thr;
    logic          rxread_o, empty_o, full_o, overrun_o, irq_o;
    logic [7:0]    data_o;
    logic [DL:0]   count_o;

    logic [7:0]    exp_q[$];
    logic          exp_ovr;
    int            n_cmp = 0;
    int            n_fail = 0;

    wire [16:0] dut_st = {data_o, empty_o, full_o, count_o, overrun_o, irq_o};
    localparam logic [16:0] RESET_ST = {8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};

    rx_fifo_stage #(.DEPTH_LOG2(DL)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .rxav_i(rxav), .rxdata_i(rxd),
        .rxread_o(rxread_o), .rd_i(rd), .data_o(data_o), .empty_o(empty_o),
        .full_o(full_o), .count_o(count_o), .overrun_o(overrun_o),
        .clr_ovr_i(clr), .thresh_i(thr), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue updated by the FIFO rules once per clock edge.
    task automatic model_step();
        bit do_pop, do_push;
        if (!rst_n) begin
            exp_q.delete();
            exp_ovr = 1'b0;
            return;
        end
        do_pop  = rd && (exp_q.size() > 0);
        do_push = rxav && ((exp_q.size() < DEPTH) || do_pop);
        if (clr) exp_ovr = 1'b0;
        if (rxav && !do_push) exp_ovr = 1'b1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(rxd);
    endtask

    function automatic logic exp_irq();
`ifdef RX_FIFO_THRESH_EN
        int t = (thr == 0) ? 1 : int'(thr);
        return (exp_q.size() >= t) || exp_ovr;
`else
        return (exp_q.size() != 0) || exp_ovr;
`endif
    endfunction

    function automatic logic [16:0] exp_st();
        int n = exp_q.size();
        logic [7:0] d = (n > 0) ? exp_q[0] : 8'h00;
        return {d, n == 0, n == DEPTH, 5'(n), exp_ovr, exp_irq()};
    endfunction

    task automatic set_in(input logic a, input logic [7:0] d, input logic r, input logic c);
        rxav = a; rxd = d; rd = r; clr = c;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 8'h00, 0, 0);
        thr = 5'd4;
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (dut_st !== RESET_ST) begin
            n_fail++; $display("FAIL reset_state got=%h want=%h", dut_st, RESET_ST);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (dut_st !== exp_st()) begin
            n_fail++; $display("FAIL reset_release got=%h want=%h", dut_st, exp_st());
        end
    endtask

    task automatic test_basic();
        logic [7:0] b [3];
        b[0] = 8'h55; b[1] = 8'hA3; b[2] = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            set_in(1, b[i], 0, 0);
            #1;
            n_cmp++;
            if (rxread_o !== 1'b1) begin
                n_fail++; $display("FAIL basic_ack byte=%0d got=%b want=1", i, rxread_o);
            end
            tick();
            set_in(0, 8'h00, 0, 0);
            #1;
            n_cmp++;
            if (rxread_o !== 1'b0) begin
                n_fail++; $display("FAIL basic_ack_idle byte=%0d got=%b want=0", i, rxread_o);
            end
            repeat (19) tick();
        end
        n_cmp++;
        if (count_o !== 5'd3 || data_o !== 8'h55) begin
            n_fail++; $display("FAIL basic_fill count=%0d data=%h want 3/55", count_o, data_o);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (data_o !== b[i] || empty_o !== 1'b0) begin
                n_fail++; $display("FAIL basic_pop%0d data=%h empty=%b want %h/0", i, data_o, empty_o, b[i]);
            end
            set_in(0, 8'h00, 1, 0);
            tick();
            set_in(0, 8'h00, 0, 0);
            tick();
        end
        n_cmp++;
        if (empty_o !== 1'b1 || dut_st !== exp_st()) begin
            n_fail++; $display("FAIL basic_drained got=%h want=%h", dut_st, exp_st());
        end
    endtask

    task automatic test_full_drop();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 8'(i), 0, 0);
            tick();
        end
        set_in(0, 8'h00, 0, 0);
        tick();
        n_cmp++;
        if (full_o !== 1'b1 || count_o !== 5'd16) begin
            n_fail++; $display("FAIL full_flag full=%b count=%0d want 1/16", full_o, count_o);
        end
        set_in(1, 8'hEE, 0, 0);
        #1;
        n_cmp++;
        if (rxread_o !== 1'b1) begin
            n_fail++; $display("FAIL drop_ack got=%b want=1", rxread_o);
        end
        tick();
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (overrun_o !== 1'b1 || count_o !== 5'd16 || data_o !== 8'h00) begin
            n_fail++; $display("FAIL drop ovr=%b count=%0d data=%h want 1/16/00", overrun_o, count_o, data_o);
        end
        n_cmp++;
        if (dut_st !== exp_st()) begin
            n_fail++; $display("FAIL drop_model got=%h want=%h", dut_st, exp_st());
        end
    endtask

    task automatic test_full_push_pop();
        set_in(0, 8'h00, 0, 1);
        tick();
        set_in(1, 8'h77, 1, 0);
        tick();
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (count_o !== 5'd16 || overrun_o !== 1'b0 || full_o !== 1'b1) begin
            n_fail++; $display("FAIL full_pushpop count=%0d ovr=%b full=%b want 16/0/1", count_o, overrun_o, full_o);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dut_st !== exp_st()) begin
                n_fail++; $display("FAIL drain%0d got=%h want=%h", i, dut_st, exp_st());
            end
            if (i == DEPTH - 1) begin
                n_cmp++;
                if (data_o !== 8'h77) begin
                    n_fail++; $display("FAIL last_byte got=%h want=77", data_o);
                end
            end
            set_in(0, 8'h00, 1, 0);
            tick();
        end
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (empty_o !== 1'b1) begin
            n_fail++; $display("FAIL drained_empty got=%b want=1", empty_o);
        end
    endtask

    task automatic test_empty_pop();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 8'h00, 1, 0);
            tick();
            n_cmp++;
            if (count_o !== 5'd0 || empty_o !== 1'b1) begin
                n_fail++; $display("FAIL underflow%0d count=%0d empty=%b want 0/1", i, count_o, empty_o);
            end
        end
        set_in(1, 8'h3C, 0, 0);
        tick();
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (data_o !== 8'h3C || count_o !== 5'd1) begin
            n_fail++; $display("FAIL after_underflow data=%h count=%0d want 3C/1", data_o, count_o);
        end
        set_in(0, 8'h00, 1, 0);
        tick();
        set_in(0, 8'h00, 0, 0);
    endtask

    task automatic test_wrap();
        int errs = 0;
        for (int i = 0; i < 20; i++) begin
            set_in(1, 8'($urandom_range(0, 255)), (i >= 8 && i < 18), 0);
            tick();
            n_cmp++;
            if (dut_st !== exp_st()) begin
                n_fail++; errs++;
                $display("FAIL wrap%0d got=%h want=%h", i, dut_st, exp_st());
            end
        end
        while (exp_q.size() < DEPTH) begin
            set_in(1, 8'($urandom_range(0, 255)), 0, 0);
            tick();
        end
        set_in(1, 8'hAA, 0, 1);
        tick();
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (overrun_o !== 1'b1 || count_o !== 5'd16) begin
            n_fail++; $display("FAIL clr_vs_drop ovr=%b count=%0d want 1/16", overrun_o, count_o);
        end
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (dut_st !== exp_st()) begin
                n_fail++; $display("FAIL wrap_drain got=%h want=%h", dut_st, exp_st());
            end
            set_in(0, 8'h00, 1, 0);
            tick();
        end
        set_in(0, 8'h00, 0, 1);
        tick();
        set_in(0, 8'h00, 0, 0);
    endtask

    task automatic test_irq();
        thr = 5'd4;
        tick();
        n_cmp++;
        if (irq_o !== 1'b0) begin
            n_fail++; $display("FAIL irq_idle got=%b want=0", irq_o);
        end
`ifdef RX_FIFO_THRESH_EN
        for (int i = 0; i < 3; i++) begin
            set_in(1, 8'(i + 8'h40), 0, 0);
            tick();
        end
        set_in(0, 8'h00, 0, 0);
        tick();
        n_cmp++;
        if (irq_o !== 1'b0 || count_o !== 5'd3) begin
            n_fail++; $display("FAIL irq_at3 irq=%b count=%0d want 0/3", irq_o, count_o);
        end
        set_in(1, 8'h43, 0, 0);
        tick();
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (irq_o !== 1'b1 || count_o !== 5'd4) begin
            n_fail++; $display("FAIL irq_at4 irq=%b count=%0d want 1/4", irq_o, count_o);
        end
        set_in(0, 8'h00, 1, 0);
        tick();
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (irq_o !== 1'b0) begin
            n_fail++; $display("FAIL irq_after_pop got=%b want=0", irq_o);
        end
`else
        set_in(1, 8'h40, 0, 0);
        tick();
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (irq_o !== 1'b1) begin
            n_fail++; $display("FAIL irq_first_push got=%b want=1", irq_o);
        end
`endif
        while (exp_q.size() > 0) begin
            set_in(0, 8'h00, 1, 0);
            tick();
        end
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (dut_st !== exp_st()) begin
            n_fail++; $display("FAIL irq_drained got=%h want=%h", dut_st, exp_st());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            set_in(1, 8'(8'h90 + i), 0, 0);
            tick();
        end
        set_in(0, 8'h00, 0, 0);
        n_cmp++;
        if (count_o !== 5'd7) begin
            n_fail++; $display("FAIL midfill count=%0d want=7", count_o);
        end
        set_in(1, 8'hC5, 0, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_st !== RESET_ST) begin
            n_fail++; $display("FAIL async_reset got=%h want=%h", dut_st, RESET_ST);
        end
        exp_q.delete();
        exp_ovr = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (dut_st !== RESET_ST) begin
            n_fail++; $display("FAIL reset_hold got=%h want=%h", dut_st, RESET_ST);
        end
        set_in(0, 8'h00, 0, 0);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (dut_st !== exp_st()) begin
            n_fail++; $display("FAIL reset_after got=%h want=%h", dut_st, exp_st());
        end
    endtask

    task automatic test_random();
        int p_av, p_rd;
        for (int ph = 0; ph < 4; ph++) begin
            p_av = (ph % 2 == 0) ? 70 : 30;
            p_rd = (ph % 2 == 0) ? 25 : 70;
            for (int i = 0; i < 200; i++) begin
                set_in($urandom_range(0, 99) < p_av, 8'($urandom_range(0, 255)),
                       $urandom_range(0, 99) < p_rd, $urandom_range(0, 15) == 0);
                thr = 5'($urandom_range(0, DEPTH));
                #1;
                n_cmp++;
                if (rxread_o !== rxav) begin
                    n_fail++; $display("FAIL rand_ack ph=%0d i=%0d got=%b want=%b", ph, i, rxread_o, rxav);
                end
                tick();
                n_cmp++;
                if (dut_st !== exp_st()) begin
                    n_fail++; $display("FAIL rand ph=%0d i=%0d got=%h want=%h", ph, i, dut_st, exp_st());
                end
            end
        end
        set_in(0, 8'h00, 0, 0);
    endtask

    initial begin
        exp_ovr = 1'b0;
        test_reset();
        test_basic();
        test_full_drop();
        test_full_push_pop();
        test_empty_pop();
        test_wrap();
        test_irq();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
